user_bus_ctrl: RTL and testbench



---
 rtl/user_bus_ctrl.sv | 161 ++++++++++++++++
 tb/tb_user_bus_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/user_bus_ctrl.sv
// user_bus_ctrl: 8080 host bus front end with window address counters and pixel FIFO.
// Define USER_RDBACK_EN to let RD return the register selected by cmd; otherwise RD returns the status word.
module user_bus_ctrl #(
  parameter int H_RES = 800,
  parameter int V_RES = 480,
  parameter int FIFO_DEPTH = 8,
  localparam int COL_W = $clog2(H_RES),
  localparam int ROW_W = $clog2(V_RES),
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1,
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic             osc_clk,
  input  logic             RST,
  inout  wire  [15:0]      DATA,
  input  logic             CS,
  input  logic             RS,
  input  logic             WR,
  input  logic             RD,
  output logic             LR,
  output logic             UD,
  output logic [3:0]       pwm_backlight,
  output logic [2:0]       page_show,
  output logic [2:0]       page_set,
  output logic [ROW_W-1:0] row_add,
  output logic [COL_W-1:0] col_add,
  input  logic             startup_inc,
  output logic             startup,
  input  logic             FIFO_RD_req,
  output logic             FIFO_empty,
  output logic [15:0]      FIFO_data,
  output logic [LVL_W-1:0] FIFO_level
);
  localparam logic [2:0] IDLE = 3'd0, WR_CMD = 3'd1, WR_DATA = 3'd2, RD_DATA = 3'd3, ST_END = 3'd4;
  logic [3:0] sm_q, ss_q;
  logic [2:0] state_q, state_d;
  logic [3:0] cmd_q, pwm_q;
  logic [2:0] show_q, set_q;
  logic lr_q, ud_q, inc_q, ovf_q, reload_q, startup_q, oe_q;
  logic [ROW_W-1:0] row_s_q, row_e_q, row_q;
  logic [COL_W-1:0] col_s_q, col_e_q, col_q;
  logic [15:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wp_q, rp_q;
  logic [LVL_W-1:0] level_q;
  logic [15:0] dout_q, rd_word, status;
  logic end_exit, wr_dat, row_s_acc, col_s_acc, push_req, full, empty, pop, push;
  logic col_end, row_end, col_en, row_en;
  // synchronised strobes, packed as {CS,RS,WR,RD}
  always_ff @(posedge osc_clk) begin
    if (RST) begin
      sm_q <= '1;
      ss_q <= '1;
    end else begin
      sm_q <= {CS, RS, WR, RD};
      ss_q <= sm_q;
    end
  end
  assign end_exit = ss_q[3] | (ss_q[1] & ss_q[0]);
  always_comb begin
    state_d = state_q == IDLE ? (ss_q == 4'b0001 ? WR_CMD : ss_q == 4'b0101 ? WR_DATA :
                                 ss_q == 4'b0110 ? RD_DATA : IDLE) :
              state_q == ST_END ? (end_exit ? IDLE : ST_END) : ST_END;
  end
  assign wr_dat    = state_q == WR_DATA;
  assign row_s_acc = wr_dat && cmd_q == 4'h2 && DATA <= 16'(row_e_q);
  assign col_s_acc = wr_dat && cmd_q == 4'h3 && DATA <= 16'(col_e_q);
  assign push_req  = wr_dat && cmd_q == 4'hF;
  assign full      = level_q == LVL_W'(FIFO_DEPTH);
  assign empty     = level_q == '0;
  assign pop       = FIFO_RD_req & ~empty;
  assign push      = push_req & (~full | pop);
  assign col_end   = col_q == col_e_q;
  assign row_end   = row_q == row_e_q;
  assign col_en    = (~inc_q | row_end) & startup_inc;
  assign row_en    = (inc_q | col_end) & startup_inc;
  assign status    = {ovf_q, startup_q, {(14-LVL_W){1'b0}}, level_q};
`ifdef USER_RDBACK_EN
  always_comb begin
    case (cmd_q)
      4'h1: rd_word = 16'(pwm_q);
      4'h2: rd_word = 16'(row_s_q);
      4'h3: rd_word = 16'(col_s_q);
      4'h4: rd_word = 16'(show_q);
      4'h5: rd_word = 16'(set_q);
      4'h6: rd_word = 16'(row_e_q);
      4'h7: rd_word = 16'(col_e_q);
      4'hC: rd_word = 16'({ud_q, lr_q});
      4'hD: rd_word = 16'(inc_q);
      default: rd_word = status;
    endcase
  end
`else
  assign rd_word = status;
`endif
  always_ff @(posedge osc_clk) begin
    if (RST) begin
      state_q <= IDLE;
      cmd_q <= '0;
      pwm_q <= '0;
      show_q <= '0;
      set_q <= '0;
      {lr_q, ud_q, inc_q, ovf_q, reload_q, startup_q, oe_q} <= '0;
      row_s_q <= '0;
      col_s_q <= '0;
      row_e_q <= ROW_W'(V_RES - 1);
      col_e_q <= COL_W'(H_RES - 1);
      row_q <= '0;
      col_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      reload_q <= row_s_acc | col_s_acc;
      if (state_q == WR_CMD) cmd_q <= DATA[3:0];
      if (wr_dat) begin
        case (cmd_q)
          4'h1: pwm_q <= DATA[3:0];
          4'h4: show_q <= DATA[2:0];
          4'h5: set_q <= DATA[2:0];
          4'h6: if (DATA < 16'(V_RES)) row_e_q <= DATA[ROW_W-1:0];
          4'h7: if (DATA < 16'(H_RES)) col_e_q <= DATA[COL_W-1:0];
          4'hC: {ud_q, lr_q} <= DATA[1:0];
          4'hD: inc_q <= DATA[0];
          4'hE: ovf_q <= 1'b0;
          default: ;
        endcase
      end
      if (row_s_acc) row_s_q <= DATA[ROW_W-1:0];
      if (col_s_acc) col_s_q <= DATA[COL_W-1:0];
      if (push_req && full && !pop) ovf_q <= 1'b1;
      if (reload_q || (col_end && col_en)) col_q <= col_s_q;
      else if (col_en) col_q <= col_q + COL_W'(1);
      if (reload_q || (row_end && row_en)) row_q <= row_s_q;
      else if (row_en) row_q <= row_q + ROW_W'(1);
      if (col_en && col_end && row_end) startup_q <= 1'b1;
      if (push) wp_q <= wp_q + PTR_W'(1);
      if (pop) rp_q <= rp_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
      if (state_q == RD_DATA) begin
        dout_q <= rd_word;
        oe_q <= 1'b1;
      end else if (state_q == ST_END && end_exit) oe_q <= 1'b0;
    end
  end
  always_ff @(posedge osc_clk) begin
    if (push) mem_q[wp_q] <= DATA;
  end
  assign DATA          = oe_q ? dout_q : 16'hzzzz;
  assign LR            = lr_q;
  assign UD            = ud_q;
  assign pwm_backlight = pwm_q;
  assign page_show     = show_q;
  assign page_set      = set_q;
  assign row_add       = row_q;
  assign col_add       = col_q;
  assign startup       = startup_q;
  assign FIFO_empty    = empty;
  assign FIFO_data     = mem_q[rp_q];
  assign FIFO_level    = level_q;
endmodule

// File: tb/tb_user_bus_ctrl.sv
// tb_user_bus_ctrl: scoreboard bench for user_bus_ctrl driving the 8080 bus cycle by cycle.
module tb_user_bus_ctrl;
  logic osc_clk = 0, RST = 1, CS = 1, RS = 1, WR = 1, RD = 1;
  logic startup_inc = 0, FIFO_RD_req = 0, tb_oe = 0;
  logic [15:0] tb_dq = '0;
  tri1 [15:0] DATA;
  logic LR, UD, startup, FIFO_empty;
  logic [3:0] pwm_backlight, FIFO_level;
  logic [2:0] page_show, page_set;
  logic [8:0] row_add;
  logic [9:0] col_add;
  logic [15:0] FIFO_data;
  int total = 0, bad = 0;
  logic [15:0] sbq[$];
  logic [15:0] rdq[$];
  assign DATA = tb_oe ? tb_dq : 16'hzzzz;
  always #5 osc_clk = ~osc_clk;
  user_bus_ctrl dut (
    .osc_clk(osc_clk), .RST(RST), .DATA(DATA), .CS(CS), .RS(RS), .WR(WR), .RD(RD),
    .LR(LR), .UD(UD), .pwm_backlight(pwm_backlight), .page_show(page_show), .page_set(page_set),
    .row_add(row_add), .col_add(col_add), .startup_inc(startup_inc), .startup(startup),
    .FIFO_RD_req(FIFO_RD_req), .FIFO_empty(FIFO_empty), .FIFO_data(FIFO_data), .FIFO_level(FIFO_level)
  );
  task host_write(input logic rs, input logic [15:0] v);
    @(negedge osc_clk);
    tb_dq = v; tb_oe = 1; CS = 0; RS = rs; WR = 0;
    repeat (6) @(negedge osc_clk);
    WR = 1; CS = 1;
    repeat (6) @(negedge osc_clk);
    tb_oe = 0;
  endtask
  task wr_reg(input logic [3:0] c, input logic [15:0] v);
    host_write(0, {12'h0, c});
    host_write(1, v);
  endtask
  task host_read(input string nm);
    logic [15:0] exp;
    exp = rdq.size() != 0 ? rdq.pop_front() : 16'h0;
    @(negedge osc_clk);
    CS = 0; RS = 1; RD = 0;
    repeat (3) @(negedge osc_clk);
    total++;
    if (DATA !== 16'hFFFF) begin bad++; $display("FAIL %s_early: DATA=%h want %h", nm, DATA, 16'hFFFF); end
    @(negedge osc_clk);
    total++;
    if (DATA !== exp) begin bad++; $display("FAIL %s_value: DATA=%h want %h", nm, DATA, exp); end
    repeat (2) @(negedge osc_clk);
    RD = 1; CS = 1;
    repeat (2) @(negedge osc_clk);
    total++;
    if (DATA !== exp) begin bad++; $display("FAIL %s_hold: DATA=%h want %h", nm, DATA, exp); end
    @(negedge osc_clk);
    total++;
    if (DATA !== 16'hFFFF) begin bad++; $display("FAIL %s_release: DATA=%h want %h", nm, DATA, 16'hFFFF); end
    repeat (3) @(negedge osc_clk);
  endtask
  task pulse_inc();
    @(negedge osc_clk) startup_inc = 1;
    @(negedge osc_clk) startup_inc = 0;
  endtask
  task test_reset();
    RST = 1; CS = 1; RS = 1; WR = 1; RD = 1; tb_oe = 0; FIFO_RD_req = 0; startup_inc = 0;
    repeat (3) @(negedge osc_clk);
    RST = 0;
    total += 6;
    if (FIFO_empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", FIFO_empty); end
    if (FIFO_level !== 4'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", FIFO_level); end
    if (row_add !== 9'd0) begin bad++; $display("FAIL rst_row: got %0d want 0", row_add); end
    if (col_add !== 10'd0) begin bad++; $display("FAIL rst_col: got %0d want 0", col_add); end
    if (DATA !== 16'hFFFF) begin bad++; $display("FAIL rst_data: got %h want released", DATA); end
    if ({startup, pwm_backlight, LR, UD} !== 7'd0) begin bad++; $display("FAIL rst_regs: got %b want 0", {startup, pwm_backlight, LR, UD}); end
  endtask
  task test_col_end();
    wr_reg(4'h7, 16'h03FF);
    wr_reg(4'h3, 16'd798);
    total++;
    if (col_add !== 10'd798) begin bad++; $display("FAIL col_reload: got %0d want 798", col_add); end
    pulse_inc();
    total++;
    if (col_add !== 10'd799) begin bad++; $display("FAIL col_799: got %0d want 799", col_add); end
    pulse_inc();
    total += 2;
    if (col_add !== 10'd798) begin bad++; $display("FAIL col_wrap799: got %0d want 798", col_add); end
    if (row_add !== 9'd1) begin bad++; $display("FAIL row_step: got %0d want 1", row_add); end
    wr_reg(4'h7, 16'h0010);
    wr_reg(4'h3, 16'd20);
    total++;
    if (col_add !== 10'd798) begin bad++; $display("FAIL col_s_reject: got %0d want 798", col_add); end
    wr_reg(4'h3, 16'd15);
    total += 2;
    if (col_add !== 10'd15) begin bad++; $display("FAIL col_s15: got %0d want 15", col_add); end
    if (row_add !== 9'd0) begin bad++; $display("FAIL row_reload: got %0d want 0", row_add); end
    pulse_inc();
    total++;
    if (col_add !== 10'd16) begin bad++; $display("FAIL col_16: got %0d want 16", col_add); end
    pulse_inc();
    total++;
    if (col_add !== 10'd15) begin bad++; $display("FAIL col_wrap16: got %0d want 15", col_add); end
  endtask
  task test_window();
    test_reset();
    wr_reg(4'h7, 16'd3);
    wr_reg(4'h6, 16'd1);
    wr_reg(4'h2, 16'd0);
    wr_reg(4'h3, 16'd0);
    wr_reg(4'hD, 16'd0);
    for (int k = 1; k <= 8; k++) begin
      pulse_inc();
      total += 3;
      if (col_add !== 10'(k % 4)) begin bad++; $display("FAIL win_col%0d: got %0d want %0d", k, col_add, k % 4); end
      if (row_add !== 9'((k / 4) % 2)) begin bad++; $display("FAIL win_row%0d: got %0d want %0d", k, row_add, (k / 4) % 2); end
      if (startup !== (k == 8)) begin bad++; $display("FAIL win_startup%0d: got %b want %b", k, startup, k == 8); end
    end
  endtask
  task test_fifo_overflow();
    logic [15:0] w;
    test_reset();
    sbq.delete();
    host_write(0, 16'h000F);
    for (int i = 0; i < 9; i++) begin
      w = 16'hA000 + 16'(i);
      if (sbq.size() < 8) sbq.push_back(w);
      host_write(1, w);
      total += 2;
      if (FIFO_level !== 4'(sbq.size())) begin bad++; $display("FAIL fifo_level%0d: got %0d want %0d", i, FIFO_level, sbq.size()); end
      if (FIFO_data !== sbq[0]) begin bad++; $display("FAIL fifo_head%0d: got %h want %h", i, FIFO_data, sbq[0]); end
    end
    rdq.push_back(16'h8008);
    host_read("status_ovf");
    wr_reg(4'hE, 16'h0000);
    rdq.push_back(16'h0008);
    host_read("status_clr");
  endtask
  task test_back_to_back();
    logic [15:0] w, exp;
    w = 16'hB0B0;
    host_write(0, 16'h000F);
    @(negedge osc_clk);
    tb_dq = w; tb_oe = 1; CS = 0; RS = 1; WR = 0;
    repeat (3) @(posedge osc_clk);
    @(negedge osc_clk);
    FIFO_RD_req = 1;
    exp = sbq.pop_front();
    sbq.push_back(w);
    total++;
    if (FIFO_data !== exp) begin bad++; $display("FAIL b2b_pop: got %h want %h", FIFO_data, exp); end
    @(negedge osc_clk);
    FIFO_RD_req = 0;
    total++;
    if (FIFO_level !== 4'd8) begin bad++; $display("FAIL b2b_level: got %0d want 8", FIFO_level); end
    repeat (4) @(negedge osc_clk);
    WR = 1; CS = 1;
    repeat (6) @(negedge osc_clk);
    tb_oe = 0;
    rdq.push_back(16'h0008);
    host_read("status_b2b");
    for (int i = 0; i < 8 && sbq.size() != 0; i++) begin
      @(negedge osc_clk);
      exp = sbq.pop_front();
      total++;
      if (FIFO_data !== exp) begin bad++; $display("FAIL drain%0d: got %h want %h", i, FIFO_data, exp); end
      FIFO_RD_req = 1;
      @(negedge osc_clk);
      FIFO_RD_req = 0;
    end
    total += 2;
    if (FIFO_empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", FIFO_empty); end
    if (FIFO_level !== 4'd0) begin bad++; $display("FAIL drain_level: got %0d want 0", FIFO_level); end
    @(negedge osc_clk) FIFO_RD_req = 1;
    @(negedge osc_clk) FIFO_RD_req = 0;
    total += 2;
    if (FIFO_empty !== 1'b1) begin bad++; $display("FAIL underflow_empty: got %b want 1", FIFO_empty); end
    if (FIFO_level !== 4'd0) begin bad++; $display("FAIL underflow_level: got %0d want 0", FIFO_level); end
  endtask
  task test_readback();
    test_reset();
    wr_reg(4'h1, 16'h0009);
    wr_reg(4'h4, 16'h0005);
    wr_reg(4'h5, 16'h0003);
    wr_reg(4'hC, 16'h0002);
    total += 4;
    if (pwm_backlight !== 4'h9) begin bad++; $display("FAIL pwm: got %h want 9", pwm_backlight); end
    if (page_show !== 3'd5) begin bad++; $display("FAIL page_show: got %0d want 5", page_show); end
    if (page_set !== 3'd3) begin bad++; $display("FAIL page_set: got %0d want 3", page_set); end
    if ({UD, LR} !== 2'b10) begin bad++; $display("FAIL scan_dir: got %b want 10", {UD, LR}); end
    host_write(0, 16'h0001);
`ifdef USER_RDBACK_EN
    rdq.push_back(16'h0009);
`else
    rdq.push_back(16'h0000);
`endif
    host_read("rd_pwm");
    host_write(0, 16'h0007);
`ifdef USER_RDBACK_EN
    rdq.push_back(16'd799);
`else
    rdq.push_back(16'h0000);
`endif
    host_read("rd_col_e");
  endtask
  initial begin
    test_reset();
    test_col_end();
    test_window();
    test_fifo_overflow();
    test_back_to_back();
    test_readback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
